// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs shared between the stopwatch sequencer
// and the BCD counter / display logic.
interface stopwatch_ctrl_if;
  logic       btn_ss_n;
  logic       btn_lap_n;
  logic       btn_clr_n;
  logic       run;
  logic       count_tick;
  logic       clear;
  logic       lap_hold;
  logic       lap_strobe;
  logic [1:0] state;

  modport master (
    output btn_ss_n, btn_lap_n, btn_clr_n,
    input  run, count_tick, clear, lap_hold, lap_strobe, state
  );

  modport slave (
    input  btn_ss_n, btn_lap_n, btn_clr_n,
    output run, count_tick, clear, lap_hold, lap_strobe, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons, idle/run/pause/lap FSM, gated count
// tick, counter clear and display lap-freeze controls.
module stopwatch_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);
  logic             s1, s2, deb;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 != deb) begin
        // the Nth consecutive differing sample accepts the new level
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb   <= s2;
          cnt   <= '0;
          press <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV        = 120000,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic reset,
  stopwatch_ctrl_if.slave sw
);
  localparam int NUM_BTN = 3;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] LAP   = 2'd3;

  logic [NUM_BTN-1:0] btn_n, press;
  logic               ev_ss, ev_lap, ev_clr;
  logic [1:0]         state, st_nxt;
  logic               run, run_nxt, lap_hold, lap_strobe, clear, count_tick;
  logic               clr_take, strobe_nxt, presc_zero;
  logic [CNT_W-1:0]   presc;

  assign btn_n = {sw.btn_clr_n, sw.btn_lap_n, sw.btn_ss_n};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    stopwatch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .btn_n(btn_n[g]),
      .press(press[g])
    );
  end

  // same-cycle events resolve ss > lap > clr; losers are dropped
  assign ev_ss  = press[0];
  assign ev_lap = press[1] & ~press[0];
  assign ev_clr = press[2] & ~press[1] & ~press[0];

  always_comb begin
    st_nxt     = state;
    clr_take   = 1'b0;
    strobe_nxt = 1'b0;
    presc_zero = 1'b0;
    case (state)
      IDLE: begin
        if (ev_ss) begin
          st_nxt     = RUN;
          presc_zero = 1'b1;
        end else if (ev_clr) begin
          clr_take = 1'b1;
        end
      end
      RUN: begin
        if (ev_ss) begin
          st_nxt = PAUSE;
        end else if (ev_lap) begin
          st_nxt     = LAP;
          strobe_nxt = 1'b1;
        end
      end
      LAP: begin
        if (ev_ss)       st_nxt = PAUSE;
        else if (ev_lap) st_nxt = RUN;
      end
      PAUSE: begin
        if (ev_ss) begin
          st_nxt = RUN;
        end else if (ev_clr) begin
          st_nxt     = IDLE;
          clr_take   = 1'b1;
          presc_zero = 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign run_nxt = (st_nxt == RUN) || (st_nxt == LAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      run        <= 1'b0;
      lap_hold   <= 1'b0;
      lap_strobe <= 1'b0;
      clear      <= 1'b0;
      count_tick <= 1'b0;
      presc      <= '0;
    end else begin
      state      <= st_nxt;
      run        <= run_nxt;
      lap_hold   <= (st_nxt == LAP);
      lap_strobe <= strobe_nxt;
      clear      <= clr_take;
      count_tick <= 1'b0;
      // only advance when running on both sides of the edge, so a tick can
      // never land in the first cycle of PAUSE and the phase is kept intact
      if (presc_zero) begin
        presc <= '0;
      end else if (run && run_nxt) begin
        if (presc == CNT_W'(TICK_DIV - 1)) begin
          presc      <= '0;
          count_tick <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign sw.state      = state;
  assign sw.run        = run;
  assign sw.lap_hold   = lap_hold;
  assign sw.lap_strobe = lap_strobe;
  assign sw.clear      = clear;
  assign sw.count_tick = count_tick;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=5, DEBOUNCE_CYCLES=4.
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   ticks;
  int   first;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.TICK_DIV(5), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // m = {clr, lap, ss}; held for 7 edges, the FSM moves on the 7th
  task automatic press(input logic [2:0] m);
    {sw.btn_clr_n, sw.btn_lap_n, sw.btn_ss_n} = ~m;
    idle(7);
    {sw.btn_clr_n, sw.btn_lap_n, sw.btn_ss_n} = 3'b111;
  endtask

  task automatic count_ticks(input int n, output int cnt, output int first_at);
    cnt = 0;
    first_at = -1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (sw.count_tick) begin
        if (first_at < 0) first_at = i;
        cnt++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {sw.btn_clr_n, sw.btn_lap_n, sw.btn_ss_n} = 3'b111;
    idle(3);
    chk("rst_state", sw.state, 0);
    chk("rst_run", sw.run, 0);
    chk("rst_tick", sw.count_tick, 0);
    chk("rst_clear", sw.clear, 0);
    chk("rst_hold", sw.lap_hold, 0);
    chk("rst_strobe", sw.lap_strobe, 0);
    reset = 1'b0;
    idle(2);

    // 3-cycle glitch is filtered
    sw.btn_ss_n = 1'b0;
    idle(3);
    sw.btn_ss_n = 1'b1;
    idle(10);
    chk("glitch_state", sw.state, 0);

    // long press: RUN on the 7th edge after the first low sample
    sw.btn_ss_n = 1'b0;
    idle(6);
    chk("ss_pre_state", sw.state, 0);
    step();
    chk("ss_state", sw.state, 1);
    chk("ss_run", sw.run, 1);
    ticks = 0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 3) sw.btn_ss_n = 1'b1;
      if (sw.count_tick) begin
        if (first < 0) first = i;
        ticks++;
      end
    end
    chk("tick_first", first, 5);
    chk("tick_cnt20", ticks, 4);

    // pause with prescaler at 3, then resume: tick after 2 cycles
    idle(2);
    press(3'b001);
    chk("pause_state", sw.state, 2);
    chk("pause_run", sw.run, 0);
    chk("pause_tick0", sw.count_tick, 0);
    count_ticks(30, ticks, first);
    chk("pause_ticks", ticks, 0);
    press(3'b001);
    chk("resume_state", sw.state, 1);
    step();
    chk("resume_t1", sw.count_tick, 0);
    step();
    chk("resume_t2", sw.count_tick, 1);

    // lap enter / exit
    press(3'b010);
    chk("lap_state", sw.state, 3);
    chk("lap_strobe", sw.lap_strobe, 1);
    chk("lap_hold", sw.lap_hold, 1);
    chk("lap_run", sw.run, 1);
    step();
    chk("lap_strobe_end", sw.lap_strobe, 0);
    chk("lap_hold_kept", sw.lap_hold, 1);
    count_ticks(10, ticks, first);
    chk("lap_ticks", ticks, 2);
    press(3'b010);
    chk("unlap_state", sw.state, 1);
    chk("unlap_hold", sw.lap_hold, 0);
    chk("unlap_strobe", sw.lap_strobe, 0);

    // clr ignored in RUN
    idle(8);
    press(3'b100);
    chk("run_clr_state", sw.state, 1);
    chk("run_clr_clear", sw.clear, 0);
    step();
    chk("run_clr_clear2", sw.clear, 0);

    // ss beats lap
    idle(8);
    press(3'b011);
    chk("both_state", sw.state, 2);
    chk("both_strobe", sw.lap_strobe, 0);
    chk("both_hold", sw.lap_hold, 0);
    step();
    chk("both_strobe2", sw.lap_strobe, 0);

    // clr from PAUSE
    idle(8);
    press(3'b100);
    chk("pclr_state", sw.state, 0);
    chk("pclr_clear", sw.clear, 1);
    chk("pclr_run", sw.run, 0);
    chk("pclr_tick", sw.count_tick, 0);
    step();
    chk("pclr_clear_end", sw.clear, 0);

    // clr in IDLE pulses clear, lap in IDLE ignored
    idle(8);
    press(3'b100);
    chk("iclr_state", sw.state, 0);
    chk("iclr_clear", sw.clear, 1);
    idle(8);
    press(3'b010);
    chk("ilap_state", sw.state, 0);
    chk("ilap_strobe", sw.lap_strobe, 0);

    // fresh start: tick exactly 5 cycles after run rises
    idle(8);
    press(3'b001);
    chk("start_state", sw.state, 1);
    idle(4);
    chk("start_t4", sw.count_tick, 0);
    step();
    chk("start_t5", sw.count_tick, 1);

    // reset lands on the edge that would produce the next tick
    idle(4);
    reset = 1'b1;
    step();
    chk("mrst_state", sw.state, 0);
    chk("mrst_run", sw.run, 0);
    chk("mrst_tick", sw.count_tick, 0);
    reset = 1'b0;
    step();
    chk("mrst_tick2", sw.count_tick, 0);
    chk("mrst_state2", sw.state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
